// File: rtl/pong_pkg.sv
// pong_pkg: shared FSM encoding, reset ball position, net geometry and score helper
package pong_pkg;
  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, POINT = 2'd2} state_t;
  localparam logic [9:0] BALL_X0 = 10'd316;
  localparam logic [9:0] BALL_Y0 = 10'd236;
  localparam logic [9:0] NET_X_LO = 10'd318;
  localparam logic [9:0] NET_X_HI = 10'd321;
  localparam int NET_DASH_BIT = 4;
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return d >= 4'd9 ? 4'd0 : d + 4'd1;
  endfunction
endpackage

// File: rtl/pong_render.sv
// pong_render: ball/paddle/net box tests with aligned, registered pixel and video enable
module pong_render
  import pong_pkg::*;
#(
  parameter int BALL   = 8,
  parameter int PAD_W  = 8,
  parameter int PAD_H  = 64,
  parameter int PAD_LX = 16,
  parameter int PAD_RX = 616
) (
  input  logic       px_clk,
  input  logic       reset_n,
  input  logic [9:0] x_px,
  input  logic [9:0] y_px,
  input  logic       activevideo,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] lpad,
  input  logic [9:0] rpad,
  output logic       pix_on,
  output logic       video_en
);
  localparam logic [10:0] B  = 11'(BALL);
  localparam logic [10:0] PW = 11'(PAD_W);
  localparam logic [10:0] PH = 11'(PAD_H);
  localparam logic [10:0] LX = 11'(PAD_LX);
  localparam logic [10:0] RX = 11'(PAD_RX);
  logic [10:0] x, y, bx, by, lp, rp;
  logic act_d, hit;
  assign x  = {1'b0, x_px};
  assign y  = {1'b0, y_px};
  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign lp = {1'b0, lpad};
  assign rp = {1'b0, rpad};
  always_comb
    hit = (x >= bx && x < bx + B && y >= by && y < by + B) ||
          (x >= LX && x < LX + PW && y >= lp && y < lp + PH) ||
          (x >= RX && x < RX + PW && y >= rp && y < rp + PH) ||
          (x_px >= NET_X_LO && x_px <= NET_X_HI && !y_px[NET_DASH_BIT]);
  always_ff @(posedge px_clk or negedge reset_n)
    if (!reset_n) begin
      act_d    <= 1'b0;
      video_en <= 1'b0;
      pix_on   <= 1'b0;
    end else begin
      act_d    <= activevideo;
      video_en <= act_d;
      pix_on   <= act_d & hit;
    end
endmodule

// File: rtl/pong_engine.sv
// pong_engine: per-frame ball physics, serve/play/point FSM, scores and pixel render
module pong_engine
  import pong_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL         = 8,
  parameter int PAD_W        = 8,
  parameter int PAD_H        = 64,
  parameter int PAD_LX       = 16,
  parameter int PAD_RX       = 616,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       px_clk,
  input  logic       reset_n,
  input  logic [9:0] x_px,
  input  logic [9:0] y_px,
  input  logic       activevideo,
  input  logic       vsync,
  input  logic [9:0] lpad_y,
  input  logic [9:0] rpad_y,
  output logic       pix_on,
  output logic       video_en,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [1:0] state
);
  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [10:0] B  = 11'(BALL);
  localparam logic [10:0] SP = 11'(SPEED);
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [10:0] PH = 11'(PAD_H);
  localparam logic [10:0] LF = 11'(PAD_LX + PAD_W);
  localparam logic [10:0] RF = 11'(PAD_RX);
  localparam logic [9:0] PMAX  = 10'(V_ACTIVE - PAD_H);
  localparam logic [9:0] X_LF  = 10'(PAD_LX + PAD_W);
  localparam logic [9:0] X_RS  = 10'(PAD_RX - BALL);
  localparam logic [9:0] Y_BOT = 10'(V_ACTIVE - BALL);
  localparam logic [9:0] S10   = 10'(SPEED);
  state_t st, st_nxt;
  logic vsync_q, tick, dx, dy, scorer, dx_n, dy_n, scorer_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [9:0] ball_x_n, ball_y_n, lpad_c, rpad_c, lpad_r, rpad_r, lpad_n, rpad_n, x_mv, y_mv;
  logic [3:0] score_l_n, score_r_n;
  logic [10:0] bx, by, lp, rp;
  logic serve_done, goal_l, goal_r, hit_l, hit_r, wall_t, wall_b;
  assign tick   = vsync_q & ~vsync;
  assign lpad_c = lpad_y > PMAX ? PMAX : lpad_y;
  assign rpad_c = rpad_y > PMAX ? PMAX : rpad_y;
  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign lp = {1'b0, lpad_c};
  assign rp = {1'b0, rpad_c};
  assign state = st;
  always_comb begin
    serve_done = cnt == CW'(SERVE_FRAMES - 1);
    goal_l = !dx && bx < SP;
    goal_r = dx && bx + B + SP > HA;
    hit_l  = !dx && bx >= LF && bx - SP < LF && by + B > lp && by < lp + PH;
    hit_r  = dx && bx + B <= RF && bx + B + SP > RF && by + B > rp && by < rp + PH;
    wall_t = !dy && by < SP;
    wall_b = dy && by + B + SP > VA;
    x_mv = hit_l ? X_LF : hit_r ? X_RS : dx ? ball_x + S10 : ball_x - S10;
    y_mv = wall_t ? 10'd0 : wall_b ? Y_BOT : dy ? ball_y + S10 : ball_y - S10;
  end
  always_ff @(posedge px_clk or negedge reset_n)
    if (!reset_n) st <= SERVE;
    else st <= st_nxt;
  always_comb
    st_nxt = !tick ? st :
             st == SERVE ? (serve_done ? PLAY : SERVE) :
             st == PLAY  ? ((goal_l || goal_r) ? POINT : PLAY) : SERVE;
  always_comb begin
    cnt_n = cnt;
    ball_x_n = ball_x;
    ball_y_n = ball_y;
    dx_n = dx;
    dy_n = dy;
    scorer_n = scorer;
    score_l_n = score_l;
    score_r_n = score_r;
    lpad_n = lpad_r;
    rpad_n = rpad_r;
    if (tick) begin
      lpad_n = lpad_c;
      rpad_n = rpad_c;
      if (st == SERVE) cnt_n = serve_done ? '0 : cnt + 1'b1;
      else if (st == PLAY) begin
        if (goal_l || goal_r) scorer_n = goal_r;
        else begin
          ball_x_n = x_mv;
          ball_y_n = y_mv;
          dx_n = dx ^ (hit_l | hit_r);
          dy_n = dy ^ (wall_t | wall_b);
        end
      end else if (st == POINT) begin
        score_l_n = scorer ? bcd_inc(score_l) : score_l;
        score_r_n = scorer ? score_r : bcd_inc(score_r);
        ball_x_n = BALL_X0;
        ball_y_n = BALL_Y0;
        dx_n = scorer;
      end
    end
  end
  always_ff @(posedge px_clk or negedge reset_n)
    if (!reset_n) begin
      vsync_q <= 1'b1;
      cnt     <= '0;
      ball_x  <= BALL_X0;
      ball_y  <= BALL_Y0;
      dx      <= 1'b1;
      dy      <= 1'b1;
      scorer  <= 1'b0;
      score_l <= '0;
      score_r <= '0;
      lpad_r  <= '0;
      rpad_r  <= '0;
    end else begin
      vsync_q <= vsync;
      cnt     <= cnt_n;
      ball_x  <= ball_x_n;
      ball_y  <= ball_y_n;
      dx      <= dx_n;
      dy      <= dy_n;
      scorer  <= scorer_n;
      score_l <= score_l_n;
      score_r <= score_r_n;
      lpad_r  <= lpad_n;
      rpad_r  <= rpad_n;
    end
  pong_render #(
    .BALL(BALL), .PAD_W(PAD_W), .PAD_H(PAD_H), .PAD_LX(PAD_LX), .PAD_RX(PAD_RX)
  ) u_render (
    .px_clk(px_clk),
    .reset_n(reset_n),
    .x_px(x_px),
    .y_px(y_px),
    .activevideo(activevideo),
    .ball_x(ball_x),
    .ball_y(ball_y),
    .lpad(lpad_r),
    .rpad(rpad_r),
    .pix_on(pix_on),
    .video_en(video_en)
  );
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: randomized game and pixel stimulus checked against a frame-level reference model
module tb_pong_engine;
  logic px_clk = 1'b0, reset_n = 1'b1, activevideo = 1'b0, vsync = 1'b1;
  logic [9:0] x_px = '0, y_px = '0, lpad_y = '0, rpad_y = '0;
  logic pix_on, video_en;
  logic [3:0] score_l, score_r;
  logic [9:0] ball_x, ball_y;
  logic [1:0] state;
  int n_tests = 0, n_fail = 0;
  int m_st, m_cnt, m_bx, m_by, m_vx, m_vy, m_left_scored, m_sl, m_sr, m_lp, m_rp;
  logic av_p1 = 1'b0, av_p2 = 1'b0;
  logic [9:0] xp1 = '0, yp1 = '0;
  int prev_sl = 0, wrap_seen = 0;
  pong_engine dut (
    .px_clk(px_clk), .reset_n(reset_n), .x_px(x_px), .y_px(y_px),
    .activevideo(activevideo), .vsync(vsync), .lpad_y(lpad_y), .rpad_y(rpad_y),
    .pix_on(pix_on), .video_en(video_en), .score_l(score_l), .score_r(score_r),
    .ball_x(ball_x), .ball_y(ball_y), .state(state)
  );
  always #5 px_clk = ~px_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_bx = 316; m_by = 236; m_vx = 2; m_vy = 2;
    m_left_scored = 0; m_sl = 0; m_sr = 0; m_lp = 0; m_rp = 0; prev_sl = 0;
  endtask
  function automatic int clampp(input int p);
    return p > 416 ? 416 : p;
  endfunction
  function automatic bit overlap(input int by, input int pad);
    return by + 8 > pad && by < pad + 64;
  endfunction
  task automatic model_tick(input int lp_in, input int rp_in);
    int lp, rp, nx, ny;
    lp = clampp(lp_in);
    rp = clampp(rp_in);
    m_lp = lp;
    m_rp = rp;
    if (m_st == 0) begin
      m_cnt++;
      if (m_cnt == 60) begin m_cnt = 0; m_st = 1; end
    end else if (m_st == 1) begin
      nx = m_bx + m_vx;
      ny = m_by + m_vy;
      if (nx < 0) begin m_left_scored = 0; m_st = 2; end
      else if (nx + 8 > 640) begin m_left_scored = 1; m_st = 2; end
      else begin
        if (m_vx < 0 && m_bx >= 24 && nx < 24 && overlap(m_by, lp)) begin nx = 24; m_vx = 2; end
        else if (m_vx > 0 && m_bx + 8 <= 616 && nx + 8 > 616 && overlap(m_by, rp)) begin nx = 608; m_vx = -2; end
        if (ny < 0) begin ny = 0; m_vy = 2; end
        else if (ny + 8 > 480) begin ny = 472; m_vy = -2; end
        m_bx = nx;
        m_by = ny;
      end
    end else begin
      if (m_left_scored) m_sl = (m_sl + 1) % 10;
      else m_sr = (m_sr + 1) % 10;
      m_bx = 316; m_by = 236;
      m_vx = m_left_scored ? 2 : -2;
      m_st = 0;
    end
  endtask
  function automatic bit in_box(input int x, input int y, input int x0, input int y0, input int w, input int h);
    return x >= x0 && x < x0 + w && y >= y0 && y < y0 + h;
  endfunction
  function automatic bit exp_hit(input int x, input int y);
    return in_box(x, y, m_bx, m_by, 8, 8) || in_box(x, y, 16, m_lp, 8, 64) ||
           in_box(x, y, 616, m_rp, 8, 64) || (x >= 318 && x <= 321 && (y / 16) % 2 == 0);
  endfunction
  function automatic logic [9:0] rand_x();
    int m, v;
    m = $urandom_range(0, 3);
    v = m == 0 ? int'($urandom_range(0, 639)) : m == 1 ? m_bx - 4 + int'($urandom_range(0, 15)) :
        m == 2 ? 314 + int'($urandom_range(0, 11)) : ($urandom_range(0, 1) ? 12 : 612) + int'($urandom_range(0, 15));
    return 10'(v);
  endfunction
  function automatic logic [9:0] rand_y();
    int m, v;
    m = $urandom_range(0, 3);
    v = m == 0 ? int'($urandom_range(0, 479)) : m == 1 ? m_by - 4 + int'($urandom_range(0, 15)) :
        m == 2 ? m_lp - 4 + int'($urandom_range(0, 71)) : m_rp - 4 + int'($urandom_range(0, 71));
    return 10'(v);
  endfunction
  function automatic int track(input int by);
    int p;
    p = by - int'($urandom_range(0, 55));
    return p < 0 ? 0 : p;
  endfunction
  task automatic step(input logic av, input logic [9:0] x, input logic [9:0] y, input logic vs);
    @(negedge px_clk);
    check("video_en", video_en, av_p2);
    check("pix_on", pix_on, av_p2 & exp_hit(xp1, yp1));
    activevideo = av; x_px = x; y_px = y; vsync = vs;
    av_p2 = av_p1; av_p1 = av; xp1 = x; yp1 = y;
  endtask
  task automatic check_game();
    check("ball_x", ball_x, m_bx);
    check("ball_y", ball_y, m_by);
    check("state", state, m_st);
    check("score_l", score_l, m_sl);
    check("score_r", score_r, m_sr);
    if (prev_sl == 9 && score_l == 4'd0) wrap_seen = 1;
    prev_sl = score_l;
  endtask
  task automatic frame(input int phase);
    int lp, rp;
    for (int i = 0; i < 6; i++) begin
      lpad_y = 10'($urandom);
      rpad_y = 10'($urandom);
      step($urandom_range(0, 3) != 0, rand_x(), rand_y(), 1'b1);
      if (i == 0) check_game();
    end
    if (phase == 1) begin
      lp = track(m_by);
      rp = m_by < 200 ? 416 + int'($urandom_range(0, 607)) : int'($urandom_range(0, 100));
    end else begin
      lp = $urandom_range(0, 1) ? track(m_by) : int'($urandom_range(0, 1023));
      rp = $urandom_range(0, 1) ? track(m_by) : int'($urandom_range(0, 1023));
    end
    lpad_y = 10'(lp);
    rpad_y = 10'(rp);
    step(1'b0, 10'h3ff, 10'h3ff, 1'b0);
    model_tick(lp, rp);
    step(1'b0, 10'h3ff, 10'h3ff, 1'b0);
    step(1'b0, 10'h3ff, 10'h3ff, 1'b1);
  endtask
  task automatic do_reset();
    @(negedge px_clk);
    activevideo = 1'b0; vsync = 1'b1; x_px = '0; y_px = '0;
    av_p1 = 1'b0; av_p2 = 1'b0; xp1 = '0; yp1 = '0;
    @(posedge px_clk);
    #3 reset_n = 1'b0;
    #1;
    check("rst_pix_on", pix_on, 0);
    check("rst_video_en", video_en, 0);
    check("rst_score_l", score_l, 0);
    check("rst_score_r", score_r, 0);
    check("rst_ball_x", ball_x, 316);
    check("rst_ball_y", ball_y, 236);
    check("rst_state", state, 0);
    @(posedge px_clk);
    #2 reset_n = 1'b1;
    model_reset();
  endtask
  initial begin
    model_reset();
    do_reset();
    for (int f = 0; f < 2500; f++) frame(1);
    do_reset();
    for (int f = 0; f < 1400; f++) frame(2);
    check("score_wrap_seen", wrap_seen, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
